// File: rtl/multicycle_control_unit_if.sv
// Instruction-memory side of the control unit: valid/ready handshake with the instruction word.
interface multicycle_control_unit_if #(
  parameter int INSTR_W = 16
);
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;

  modport master (output instr_valid, output instruction, input instr_ready);
  modport slave  (input instr_valid, input instruction, output instr_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: latches an instruction, then sequences
// FETCH/DECODE/EXECUTE/WRITEBACK|BRANCH with hold, HALT and a retired counter.
module multicycle_control_unit #(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 4,
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_unit_if.slave ibus,
  input  logic                 hold,
  input  logic                 alu_zero,
  output logic [REG_AW-1:0]    rd,
  output logic [REG_AW-1:0]    rs,
  output logic [REG_AW-1:0]    rt,
  output logic [IMM_W-1:0]     immediate,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 select_imm,
  output logic                 reg_write,
  output logic                 branch,
  output logic                 branch_taken,
  output logic                 pc_write,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_HALT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_HALT = '1;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = {{(OPCODE_W-1){1'b1}}, 1'b0};

  state_t               state, state_nx;
  logic [INSTR_W-1:0]   ir;
  logic [OPCODE_W-1:0]  opcode;
  logic [ALU_OP_W-1:0]  ir_alu_op;
  logic                 ready;

  assign opcode    = ir[INSTR_W-1 -: OPCODE_W];
  assign rd        = ir[INSTR_W-OPCODE_W-1 -: REG_AW];
  assign rs        = ir[INSTR_W-OPCODE_W-REG_AW-1 -: REG_AW];
  assign rt        = ir[INSTR_W-OPCODE_W-2*REG_AW-1 -: REG_AW];
  assign immediate = ir[IMM_W-1:0];
  // BEQ compares by subtraction regardless of its opcode low bits
  assign ir_alu_op = (opcode == OP_BEQ) ? ALU_OP_W'(1) : opcode[ALU_OP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (ready && ibus.instr_valid) ir <= ibus.instruction;
      if (pc_write && retired != '1) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    ready      = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_op     = '0;
    select_imm = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        ready = !hold;
        if (ibus.instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_op     = ir_alu_op;
        select_imm = opcode[OPCODE_W-1];
        state_nx   = (opcode == OP_BEQ) ? S_BRANCH : S_WB;
      end
      S_WB: begin
        alu_op     = ir_alu_op;
        select_imm = opcode[OPCODE_W-1];
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = ir_alu_op;
        select_imm = opcode[OPCODE_W-1];
        branch     = 1'b1;
        pc_write   = 1'b1;
        state_nx   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_nx = S_FETCH;
    endcase
    // stall: freeze state and suppress every side-effecting pulse
    if (hold) begin
      state_nx  = state;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
    end
  end

  assign branch_taken     = branch && alu_zero;
  assign ibus.instr_ready = ready && rst_n;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; small counter width so saturation is reachable.
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst_n, hold, alu_zero;
  logic [2:0] rd, rs, rt, alu_op;
  logic [5:0] immediate;
  logic select_imm, reg_write, branch, branch_taken, pc_write, halted;
  logic [3:0] retired;
  int n_cmp = 0, n_err = 0, exp_ret = 0;

  multicycle_control_unit_if #(.INSTR_W(16)) ibus ();

  multicycle_control_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ibus(ibus), .hold(hold), .alu_zero(alu_zero),
    .rd(rd), .rs(rs), .rt(rt), .immediate(immediate), .alu_op(alu_op),
    .select_imm(select_imm), .reg_write(reg_write), .branch(branch),
    .branch_taken(branch_taken), .pc_write(pc_write), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one instruction through the full sequence, checking each cycle
  task automatic issue(input logic [15:0] ins, input logic az, input logic [2:0] ea,
                       input logic es, input logic isbr);
    @(negedge clk); ibus.instr_valid = 1'b1; ibus.instruction = ins;
    #1 chk("accept_rdy", ibus.instr_ready, 1);
    @(negedge clk); ibus.instruction = 16'hFFFF;  // must be ignored in DECODE
    #1 chk("dec_rdy", ibus.instr_ready, 0);
    chk("dec_alu", alu_op, 0);
    chk("dec_pulse", {reg_write, pc_write, branch}, 0);
    chk("dec_fields", {rd, rs, rt, immediate}, {ins[11:9], ins[8:6], ins[5:3], ins[5:0]});
    @(negedge clk); ibus.instr_valid = 1'b0;
    #1 chk("exe_alu", {alu_op, select_imm}, {ea, es});
    chk("exe_pulse", {reg_write, pc_write, branch}, 0);
    @(negedge clk); alu_zero = az;
    #1 chk("wb_alu", {alu_op, select_imm}, {ea, es});
    if (isbr) chk("br_ctl", {reg_write, pc_write, branch, branch_taken}, {3'b011, az});
    else      chk("wb_ctl", {reg_write, pc_write, branch, branch_taken}, 4'b1100);
    if (exp_ret < 15) exp_ret++;
    @(negedge clk); alu_zero = 1'b0;
    #1 chk("fetch_rdy", ibus.instr_ready, 1);
    chk("retired", retired, exp_ret);
    chk("fetch_pulse", {reg_write, pc_write, alu_op, select_imm}, 0);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; alu_zero = 1'b0;
    ibus.instr_valid = 1'b1; ibus.instruction = 16'h1234;
    #1 chk("rst_rdy", ibus.instr_ready, 0);
    chk("rst_out", {rd, rs, rt, immediate, alu_op, select_imm, reg_write, branch,
                    branch_taken, pc_write, halted, retired}, 0);
    @(negedge clk); @(negedge clk); ibus.instr_valid = 1'b0; rst_n = 1'b1;

    issue(16'h0A50, 1'b0, 3'b000, 1'b0, 1'b0);           // ADD
    chk("add_regs", {rd, rs, rt}, {3'd5, 3'd1, 3'd2});
    issue(16'h8A45, 1'b0, 3'b000, 1'b1, 1'b0);           // ADDI
    chk("addi_imm", {rd, immediate}, {3'd5, 6'h05});
    issue(16'hB2C7, 1'b0, 3'b011, 1'b1, 1'b0);           // I-type alu_op 011
    issue(16'h5000, 1'b1, 3'b101, 1'b0, 1'b0);           // R-type alu_op 101
    issue(16'hE000, 1'b1, 3'b001, 1'b1, 1'b1);           // BEQ taken
    issue(16'hE000, 1'b0, 3'b001, 1'b1, 1'b1);           // BEQ not taken

    // hold in FETCH with valid: no accept
    @(negedge clk); hold = 1'b1; ibus.instr_valid = 1'b1; ibus.instruction = 16'hF000;
    #1 chk("hold_fetch_rdy", ibus.instr_ready, 0);
    @(negedge clk); hold = 1'b0; ibus.instr_valid = 1'b0;
    #1 chk("hold_fetch_noacc", ibus.instr_ready, 1);
    chk("hold_fetch_ir", {rd, immediate}, {3'd0, 6'h00});

    // hold for 3 cycles in EXECUTE, then 1 cycle in WRITEBACK
    @(negedge clk); ibus.instr_valid = 1'b1; ibus.instruction = 16'h2A50;
    @(negedge clk); ibus.instr_valid = 1'b0;
    @(negedge clk); hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_exe_alu", alu_op, 3'b010);
      chk("hold_exe_pulse", {reg_write, pc_write, branch}, 0);
      @(negedge clk);
      if (i == 2) hold = 1'b0;
    end
    hold = 1'b1;
    #1 chk("hold_wb_pulse", {reg_write, pc_write}, 0);
    @(negedge clk); hold = 1'b0;
    #1 chk("late_wb", {reg_write, pc_write}, 2'b11);
    @(negedge clk);
    exp_ret++;
    #1 chk("hold_retired", retired, exp_ret);

    // HALT
    @(negedge clk); ibus.instr_valid = 1'b1; ibus.instruction = 16'hF000;
    @(negedge clk);
    #1 chk("halt_dec", halted, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("halted", {halted, ibus.instr_ready, reg_write, pc_write}, 4'b1000);
      chk("halt_retired", retired, exp_ret);
    end
    rst_n = 1'b0;
    #1 chk("halt_rst", {halted, ibus.instr_ready, retired}, 0);
    ibus.instr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; exp_ret = 0;
    #1 chk("post_halt_rdy", ibus.instr_ready, 1);

    // reset asserted during EXECUTE
    @(negedge clk); ibus.instr_valid = 1'b1; ibus.instruction = 16'h0A50;
    @(negedge clk); ibus.instr_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("mid_rst", {rd, rs, rt, alu_op, reg_write, pc_write, ibus.instr_ready}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 chk("mid_rst_noretire", {retired, reg_write}, 0);

    // saturation of the 4-bit retired counter
    for (int i = 0; i < 17; i++) issue(16'h1248, 1'b0, 3'b001, 1'b0, 1'b0);
    chk("sat_retired", retired, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
